// File: rtl/reg_file_sb_pkg.sv
// Shared types for the scoreboarded register file and its soft-clear sequencer.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE     = 1'b0,
        RF_CLEARING = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file access bundle: write port, two read ports, scoreboard set, soft-clear control.
interface reg_file_sb_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              LD_REG;
    logic [ADDR_W-1:0] DR;
    logic [WIDTH-1:0]  D_in;
    logic [ADDR_W-1:0] SR1;
    logic [ADDR_W-1:0] SR2;
    logic [WIDTH-1:0]  SR1_OUT;
    logic [WIDTH-1:0]  SR2_OUT;
    logic              SET_PEND;
    logic [ADDR_W-1:0] SET_ADDR;
    logic              SR1_RDY;
    logic              SR2_RDY;
    logic              CLR;
    logic              BUSY;
    logic              WR_DROP;

    modport master (
        output LD_REG, DR, D_in, SR1, SR2, SET_PEND, SET_ADDR, CLR,
        input  SR1_OUT, SR2_OUT, SR1_RDY, SR2_RDY, BUSY, WR_DROP
    );

    modport slave (
        input  LD_REG, DR, D_in, SR1, SR2, SET_PEND, SET_ADDR, CLR,
        output SR1_OUT, SR2_OUT, SR1_RDY, SR2_RDY, BUSY, WR_DROP
    );

endinterface

// File: rtl/reg_file_sb_clear_seq.sv
// Soft-clear sequencer: walks every register index once, one per cycle, busy for exactly DEPTH cycles.
// No backpressure; a request while busy is ignored.
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_we_o = 1'b0;
        done     = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req_i) begin
                    state_d = RF_CLEARING;
                    idx_d   = '0;
                end
            end
            RF_CLEARING: begin
                clr_we_o = 1'b1;
                done     = (idx_q == LAST_IDX);
                // Index wraps back to 0 as the last register is erased.
                idx_d    = done ? '0 : idx_q + ADDR_W'(1);
                if (done) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy_o     = (state_q == RF_CLEARING);
    assign clr_addr_o = idx_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file, 1 write / 2 comb read ports, optional same-cycle bypass, pending scoreboard, soft clear.
// No backpressure: writes and SET_PEND during a clear are dropped and flagged on WR_DROP next cycle.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int BYPASS = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    reg_file_sb_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam bit BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr_drop_q, wr_drop_d;

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdat;
    logic              byp1, byp2;

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (Clk),
        .rst        (Reset),
        .clr_req_i  (bus.CLR),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Storage has a single write port, shared between the user write and the clear walk.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.DR;
        mem_wdat  = bus.D_in;
        pend_d    = pend_q;
        wr_drop_d = busy & (bus.LD_REG | bus.SET_PEND);
        if (busy) begin
            mem_we   = clr_we;
            mem_addr = clr_addr;
            mem_wdat = '0;
            if (clr_we) begin
                pend_d[clr_addr] = 1'b0;
            end
        end else begin
            mem_we = bus.LD_REG;
            if (bus.LD_REG) begin
                pend_d[bus.DR] = 1'b0;
            end
            // Applied after the write's clear so a same-address set wins.
            if (bus.SET_PEND) begin
                pend_d[bus.SET_ADDR] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            pend_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            if (mem_we) begin
                data_q[mem_addr] <= mem_wdat;
            end
            pend_q    <= pend_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    assign byp1 = BYP_EN && bus.LD_REG && !busy && (bus.DR == bus.SR1);
    assign byp2 = BYP_EN && bus.LD_REG && !busy && (bus.DR == bus.SR2);

    assign bus.SR1_OUT = byp1 ? bus.D_in : data_q[bus.SR1];
    assign bus.SR2_OUT = byp2 ? bus.D_in : data_q[bus.SR2];
    assign bus.SR1_RDY = !busy && (!pend_q[bus.SR1] || byp1);
    assign bus.SR2_RDY = !busy && (!pend_q[bus.SR2] || byp2);
    assign bus.BUSY    = busy;
    assign bus.WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: 8x16 bypass, 8x16 no-bypass and 32x32 instances against a scoreboard.
module tb_reg_file_sb;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_c = 1'b1;

    always #5 clk = ~clk;

    reg_file_sb_if #(.WIDTH(16), .DEPTH(8))  a_if ();
    reg_file_sb_if #(.WIDTH(16), .DEPTH(8))  b_if ();
    reg_file_sb_if #(.WIDTH(32), .DEPTH(32)) c_if ();

    reg_file_sb #(.WIDTH(16), .DEPTH(8),  .BYPASS(1)) u_a (.Clk(clk), .Reset(rst),   .bus(a_if));
    reg_file_sb #(.WIDTH(16), .DEPTH(8),  .BYPASS(0)) u_b (.Clk(clk), .Reset(rst),   .bus(b_if));
    reg_file_sb #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) u_c (.Clk(clk), .Reset(rst_c), .bus(c_if));

    int n_chk  = 0;
    int n_pass = 0;

    string       tag_q [$];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop_chk(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got %0h, expected nothing queued", obs);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Reference model for instance A
    logic [15:0] m_dat [8];
    logic [7:0]  m_pend;
    logic        m_busy;
    logic [2:0]  m_idx;
    logic        m_drop;
    int          a_busy_seen;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dat[i] = '0;
        m_pend = '0;
        m_busy = 1'b0;
        m_idx  = '0;
        m_drop = 1'b0;
    endtask

    // One clock of instance A; entered and left just after a rising edge.
    task automatic cyc_a(input logic ld, input logic [2:0] dr, input logic [15:0] din,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic sp, input logic [2:0] sa, input logic clr);
        logic b1, b2;
        a_if.LD_REG = ld;  a_if.DR = dr;  a_if.D_in = din;
        a_if.SR1 = s1;     a_if.SR2 = s2;
        a_if.SET_PEND = sp; a_if.SET_ADDR = sa; a_if.CLR = clr;
        b1 = ld && !m_busy && (dr == s1);
        b2 = ld && !m_busy && (dr == s2);
        sb_push("a_sr1_out", b1 ? {16'h0, din} : {16'h0, m_dat[s1]});
        sb_push("a_sr2_out", b2 ? {16'h0, din} : {16'h0, m_dat[s2]});
        sb_push("a_sr1_rdy", {31'h0, !m_busy && (!m_pend[s1] || b1)});
        sb_push("a_sr2_rdy", {31'h0, !m_busy && (!m_pend[s2] || b2)});
        sb_push("a_busy",    {31'h0, m_busy});
        sb_push("a_wr_drop", {31'h0, m_drop});
        @(negedge clk);
        sb_pop_chk({16'h0, a_if.SR1_OUT});
        sb_pop_chk({16'h0, a_if.SR2_OUT});
        sb_pop_chk({31'h0, a_if.SR1_RDY});
        sb_pop_chk({31'h0, a_if.SR2_RDY});
        sb_pop_chk({31'h0, a_if.BUSY});
        sb_pop_chk({31'h0, a_if.WR_DROP});
        if (a_if.BUSY === 1'b1) a_busy_seen++;
        @(posedge clk);
        #1;
        m_drop = m_busy && (ld || sp);
        if (m_busy) begin
            m_dat[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            if (m_idx == 3'd7) m_busy = 1'b0;
            m_idx = m_idx + 3'd1;
        end else begin
            if (ld) begin
                m_dat[dr]  = din;
                m_pend[dr] = 1'b0;
            end
            if (sp) m_pend[sa] = 1'b1;
            if (clr) begin
                m_busy = 1'b1;
                m_idx  = '0;
            end
        end
    endtask

    task automatic idle_a(input logic [2:0] s1, input logic [2:0] s2);
        cyc_a(1'b0, 3'd0, 16'h0, s1, s2, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        {a_if.LD_REG, a_if.SET_PEND, a_if.CLR} = '0;
        {a_if.DR, a_if.D_in, a_if.SR1, a_if.SR2, a_if.SET_ADDR} = '0;
        {b_if.LD_REG, b_if.SET_PEND, b_if.CLR} = '0;
        {b_if.DR, b_if.D_in, b_if.SR1, b_if.SR2, b_if.SET_ADDR} = '0;
        {c_if.LD_REG, c_if.SET_PEND, c_if.CLR} = '0;
        {c_if.DR, c_if.D_in, c_if.SR1, c_if.SR2, c_if.SET_ADDR} = '0;
        model_reset();
        a_busy_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        rst_c = 1'b0;

        // Reset state, then write with bypass and read back
        idle_a(3'd0, 3'd7);
        cyc_a(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
        idle_a(3'd3, 3'd0);

        // No-bypass instance: old value during the write cycle
        b_if.LD_REG = 1'b1; b_if.DR = 3'd3; b_if.D_in = 16'hBEEF; b_if.SR1 = 3'd3;
        sb_push("b_sr1_wcyc", 32'h0);
        sb_push("b_rdy_wcyc", 32'h1);
        @(negedge clk);
        sb_pop_chk({16'h0, b_if.SR1_OUT});
        sb_pop_chk({31'h0, b_if.SR1_RDY});
        @(posedge clk); #1;
        b_if.LD_REG = 1'b0;
        sb_push("b_sr1_next", 32'hBEEF);
        @(negedge clk);
        sb_pop_chk({16'h0, b_if.SR1_OUT});
        @(posedge clk); #1;

        // Scoreboard: set, bypassed write, same-cycle set+write, different addresses
        cyc_a(1'b0, 3'd0, 16'h0,    3'd0, 3'd5, 1'b1, 3'd5, 1'b0);
        idle_a(3'd5, 3'd5);
        cyc_a(1'b1, 3'd5, 16'h0042, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0);
        idle_a(3'd0, 3'd5);
        cyc_a(1'b1, 3'd5, 16'h0777, 3'd0, 3'd5, 1'b1, 3'd5, 1'b0);
        idle_a(3'd5, 3'd5);
        cyc_a(1'b1, 3'd6, 16'h0066, 3'd6, 3'd7, 1'b1, 3'd7, 1'b0);
        idle_a(3'd6, 3'd7);

        // Reset in the middle of a clear
        cyc_a(1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 1'b0, 3'd0, 1'b1);
        repeat (3) idle_a(3'd5, 3'd7);
        a_if.SR1 = 3'd3; a_if.SR2 = 3'd7;
        #1;
        rst = 1'b1;
        #1;
        sb_push("rst_sr1_out", 32'h0);
        sb_push("rst_sr2_out", 32'h0);
        sb_push("rst_sr1_rdy", 32'h1);
        sb_push("rst_sr2_rdy", 32'h1);
        sb_push("rst_busy",    32'h0);
        sb_pop_chk({16'h0, a_if.SR1_OUT});
        sb_pop_chk({16'h0, a_if.SR2_OUT});
        sb_pop_chk({31'h0, a_if.SR1_RDY});
        sb_pop_chk({31'h0, a_if.SR2_RDY});
        sb_pop_chk({31'h0, a_if.BUSY});
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle_a(3'd0, 3'd1);

        // Fill, then clear: ordered erase, exactly 8 busy cycles
        for (int i = 0; i < 8; i++)
            cyc_a(1'b1, 3'(i), 16'h1111 * 16'(i), 3'(i), 3'(i + 1), 1'b0, 3'd0, 1'b0);
        a_busy_seen = 0;
        cyc_a(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b0, 3'd0, 1'b1);
        for (int k = 0; k < 10; k++) idle_a(3'(k), 3'(k + 7));
        chk("a_clear_len", 32'(a_busy_seen), 32'd8);
        for (int k = 0; k < 8; k += 2) idle_a(3'(k), 3'(k + 1));

        // Write+CLR together, then traffic and a second CLR while busy
        cyc_a(1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 1'b0, 3'd0, 1'b0);
        a_busy_seen = 0;
        cyc_a(1'b1, 3'd1, 16'h5A5A, 3'd1, 3'd2, 1'b0, 3'd0, 1'b1);
        idle_a(3'd1, 3'd2);
        idle_a(3'd1, 3'd2);
        cyc_a(1'b1, 3'd2, 16'hABCD, 3'd2, 3'd3, 1'b1, 3'd3, 1'b1);
        idle_a(3'd2, 3'd3);
        cyc_a(1'b0, 3'd0, 16'h0, 3'd4, 3'd5, 1'b1, 3'd6, 1'b0);
        for (int k = 0; k < 6; k++) idle_a(3'(k), 3'(k + 4));
        chk("a_clear_len_busy_traffic", 32'(a_busy_seen), 32'd8);

        // 32x32 instance: bypass read, 32-cycle clear, reset at clear cycle 10
        c_if.LD_REG = 1'b1; c_if.DR = 5'd31; c_if.D_in = 32'hDEADBEEF; c_if.SR1 = 5'd31;
        sb_push("c_sr1_byp", 32'hDEADBEEF);
        sb_push("c_sr1_rdy", 32'h1);
        @(negedge clk);
        sb_pop_chk(c_if.SR1_OUT);
        sb_pop_chk({31'h0, c_if.SR1_RDY});
        @(posedge clk); #1;
        c_if.LD_REG = 1'b0;
        c_if.CLR    = 1'b1;
        sb_push("c_sr1_stored", 32'hDEADBEEF);
        @(negedge clk);
        sb_pop_chk(c_if.SR1_OUT);
        @(posedge clk); #1;
        c_if.CLR = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (c_if.BUSY === 1'b1) cnt++;
        end
        chk("c_clear_len", 32'(cnt), 32'd32);
        sb_push("c_sr1_cleared", 32'h0);
        sb_pop_chk(c_if.SR1_OUT);

        @(posedge clk); #1;
        c_if.LD_REG = 1'b1;
        @(posedge clk); #1;
        c_if.LD_REG = 1'b0;
        c_if.CLR    = 1'b1;
        @(posedge clk); #1;
        c_if.CLR = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 10; k++) begin
            @(negedge clk);
            if (c_if.BUSY === 1'b1) cnt++;
        end
        chk("c_busy_before_rst", 32'(cnt), 32'd10);
        #2;
        rst_c = 1'b1;
        #1;
        sb_push("c_rst_busy",    32'h0);
        sb_push("c_rst_sr1_out", 32'h0);
        sb_push("c_rst_sr1_rdy", 32'h1);
        sb_pop_chk({31'h0, c_if.BUSY});
        sb_pop_chk(c_if.SR1_OUT);
        sb_pop_chk({31'h0, c_if.SR1_RDY});
        @(posedge clk); #1;
        rst_c = 1'b0;
        @(posedge clk);
        sb_push("c_post_rst_busy", 32'h0);
        @(negedge clk);
        sb_pop_chk({31'h0, c_if.BUSY});

        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
